// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, captured request, word geometry.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dmem_req_t;

    localparam int WORD_BYTES = 8;
    localparam int BYTE_OFFS  = $clog2(WORD_BYTES);

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 word array: synchronous write, registered read.
// Only the read register is reset; stored words survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetl,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (resetl) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for load/store requests with WAIT_CYCLES wait states.
// Optional MISALIGN_CHECK_EN flags byte addresses that are not word aligned.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output state_t      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a response stays stable until taken.

`ifdef MISALIGN_CHECK_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state, state_nx;
    logic [3:0]  cnt;
    dmem_req_t   in_req, req_q, cmt_req;
    logic        err_q;
    logic        accept, enter_resp, cmt_err;
    logic [AW-1:0] cmt_idx;
    logic        arr_we, arr_re;
    logic [63:0] arr_rdata;

    assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign accept = req_valid & req_ready;

    // With no wait states the commit coincides with the accept edge, so the
    // request is taken straight from the ports instead of the capture register.
    assign cmt_req = (state == IDLE) ? in_req : req_q;
    assign cmt_err = (|cmt_req.addr[63:AW+BYTE_OFFS])
                   | (MISALIGN_EN & (|cmt_req.addr[BYTE_OFFS-1:0]));
    assign cmt_idx = cmt_req.addr[AW+BYTE_OFFS-1:BYTE_OFFS];

    assign enter_resp = ~resetl & (((state == IDLE) & accept & NO_WAIT)
                                 | ((state == WAIT) & (cnt == 4'd0)));
    assign arr_we = enter_resp &  cmt_req.write & ~cmt_err;
    assign arr_re = enter_resp & ~cmt_req.write & ~cmt_err;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = NO_WAIT ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_nx = RESP;
            RESP: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetl) begin
            state <= IDLE;
            cnt   <= 4'd0;
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                req_q <= in_req;
                cnt   <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q <= cmt_err;
            end else if ((state == RESP) && resp_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk    (clk),
        .resetl (resetl),
        .we     (arr_we),
        .re     (arr_re),
        .idx    (cmt_idx),
        .wdata  (cmt_req.wdata),
        .rdata  (arr_rdata)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q;
    // Stores and faulted accesses report zero data regardless of the read register.
    assign resp_rdata = (resp_valid & ~req_q.write & ~err_q) ? arr_rdata : 64'd0;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases, reset abort, randomized traffic.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;
    localparam int AW          = $clog2(DEPTH);

`ifdef MISALIGN_CHECK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetl = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    logic [63:0]   exp_q[$];
    logic          exp_err_q[$];
    logic [63:0]   model [DEPTH];
    logic          pend_we;
    logic [AW-1:0] pend_idx;
    logic [63:0]   pend_data;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .resetl     (resetl),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"},  64'(req_ready), 64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        check({tag, "_resp_err"},   64'(resp_err), 64'd0);
        check({tag, "_state"},      64'(dbg_state), 64'(IDLE));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetl     = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetl = 1'b0;
    endtask

    // Drives one request, pushes its expected response, returns just after the accept edge.
    task automatic send_req(input logic w, input logic [63:0] a, input logic [63:0] d);
        logic          err;
        logic [AW-1:0] idx;
        err = (a[63:AW+3] != '0) || (MIS && (a[2:0] != 3'd0));
        idx = a[AW+2:3];
        exp_q.push_back((w || err) ? 64'd0 : model[idx]);
        exp_err_q.push_back(err);
        pend_we   = w && !err;
        pend_idx  = idx;
        pend_data = d;
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_resp(input int stall, input logic rr_early);
        int          lat;
        logic [63:0] exp_d;
        logic        exp_e;
        logic [63:0] hold_d;
        logic        hold_e;
        lat = 1;
        resp_ready = rr_early;
        @(negedge clk);
        check("req_ready_busy", 64'(req_ready), 64'd0);
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(WAIT_CYCLES + 1));
        exp_d = exp_q.pop_front();
        exp_e = exp_err_q.pop_front();
        if (!resp_valid) begin
            resp_ready = 1'b0;
            pend_we = 1'b0;
            return;
        end
        check("resp_rdata", resp_rdata, exp_d);
        check("resp_err", 64'(resp_err), 64'(exp_e));
        hold_d = resp_rdata;
        hold_e = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", resp_rdata, hold_d);
            check("hold_err", 64'(resp_err), 64'(hold_e));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        check("hs_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("post_hs_valid", 64'(resp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
        resp_ready = 1'b0;
        if (pend_we) model[pend_idx] = pend_data;
        pend_we = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input int stall, input logic rr_early);
        send_req(w, a, d);
        wait_resp(stall, (stall == 0) ? rr_early : 1'b0);
    endtask

    initial begin
        logic [63:0] a;
        pend_we = 1'b0;
        do_reset();
        check_idle_outputs("reset");

        txn(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, 1'b0);
        txn(1'b0, 64'h10, 64'h0, 0, 1'b1);
        txn(1'b0, 64'h10, 64'h0, 5, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b1, 64'(i * WORD_BYTES), {$urandom, $urandom}, 0, 1'($urandom_range(0, 1)));
        end
        txn(1'b0, 64'h10, 64'h0, 0, 1'b0);

        txn(1'b1, 64'h200, 64'h5555_5555_5555_5555, 0, 1'b0);
        txn(1'b0, 64'h0, 64'h0, 0, 1'b0);
        txn(1'b0, 64'h8000_0000_0000_0008, 64'h0, 1, 1'b0);

        // Reset lands on the very edge that would have committed the store.
        send_req(1'b1, 64'h18, 64'h1);
        repeat (2) @(negedge clk);
        resetl = 1'b1;
        @(negedge clk);
        resetl = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_err_q.pop_back());
        pend_we = 1'b0;
        check_idle_outputs("abort");
        txn(1'b0, 64'h18, 64'h0, 0, 1'b0);

        txn(1'b0, 64'h14, 64'h0, 0, 1'b0);

        resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_rr_valid", 64'(resp_valid), 64'd0);
            check("idle_rr_ready", 64'(req_ready), 64'd1);
        end
        resp_ready = 1'b0;

        for (int i = 0; i < 40; i++) begin
            a = 64'($urandom_range(0, DEPTH - 1) * WORD_BYTES);
            if ($urandom_range(0, 7) == 0) a[63 - $urandom_range(0, 63 - (AW + 3))] = 1'b1;
            if ($urandom_range(0, 5) == 0) a[2:0] = 3'($urandom_range(1, 7));
            txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
